// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o        operand handshake
//   dividend_i, divisor_i          unsigned operands
//   out_valid_o / out_ready_i      result handshake
//   quotient_o, remainder_o        result, held until the next completion
//   div_by_zero_o                  result came from a zero divisor
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d, q_q, q_d, r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic dbz_q, dbz_d;
    logic [WIDTH:0] a, b, t, c;
    logic [WIDTH-1:0] q_nx, r_nx;
    // Minuend keeps R's top bit so 2R+1 never overflows when the divisor is large.
    assign a = {r_q, q_q[WIDTH-1]};
    assign b = ~{1'b0, div_q};
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign t[i] = a[i] ^ b[i] ^ c[i];
        if (i < WIDTH) begin : g_c
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    // t[WIDTH] set means borrow: restore by keeping the shifted remainder.
    assign r_nx = t[WIDTH] ? a[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_nx = {q_q[WIDTH-2:0], ~t[WIDTH]};
    assign in_ready_o    = state_q == IDLE;
    assign out_valid_o   = state_q == DONE;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                div_d   = divisor_i;
                q_d     = dividend_i;
                r_d     = '0;
                state_d = CALC;
                // A zero divisor spends a single CALC cycle so its result lands one edge after accept.
                count_d = divisor_i == '0 ? CW'(1) : CW'(WIDTH);
            end
            CALC: begin
                q_d     = q_nx;
                r_d     = r_nx;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = div_q == '0 ? '1 : q_nx;
                    rem_d   = div_q == '0 ? q_q : r_nx;
                    dbz_d   = div_q == '0;
                end
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic in_ready, out_valid, dbz;
    logic [7:0] quotient, remainder;
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;
    exp_t sb[$];
    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .dividend_i(dividend),
        .divisor_i(divisor),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .quotient_o(quotient),
        .remainder_o(remainder),
        .div_by_zero_o(dbz)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(dbz), 32'(e.z));
            end
        end
    end
    task automatic run(input logic [7:0] a, input logic [7:0] b, input int hold, input bit junk);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'(1));
        e.q = b == 8'd0 ? 8'hFF : a / b;
        e.r = b == 8'd0 ? a : a % b;
        e.z = b == 8'd0;
        sb.push_back(e);
        out_ready = hold == 0;
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_in_ready", 32'(in_ready), 32'(0));
            if (junk) begin
                in_valid = 1'b1;
                dividend = 8'hAA;
                divisor = 8'h03;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), b == 8'd0 ? 32'(1) : 32'(8));
        chk("done_in_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_quotient", 32'(quotient), 32'(e.q));
            chk("hold_remainder", 32'(remainder), 32'(e.r));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'(1));
        chk("idle_out_valid", 32'(out_valid), 32'(0));
        chk("kept_quotient", 32'(quotient), 32'(e.q));
        chk("kept_remainder", 32'(remainder), 32'(e.r));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0] ra, rb;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_quotient", 32'(quotient), 32'(0));
        chk("rst_remainder", 32'(remainder), 32'(0));
        chk("rst_dbz", 32'(dbz), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(8'd100, 8'd7, 0, 1'b0);
        run(8'd255, 8'd1, 0, 1'b1);
        run(8'd3, 8'd10, 0, 1'b1);
        run(8'd37, 8'd0, 0, 1'b0);
        run(8'd9, 8'd3, 0, 1'b0);
        run(8'd200, 8'd13, 5, 1'b0);
        dividend = 8'd50;
        divisor = 8'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_quotient", 32'(quotient), 32'(0));
        chk("abort_remainder", 32'(remainder), 32'(0));
        chk("abort_dbz", 32'(dbz), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(8'd50, 8'd6, 0, 1'b0);
        run(8'd255, 8'd255, 0, 1'b0);
        run(8'd0, 8'd5, 0, 1'b0);
        run(8'd0, 8'd0, 0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            if (k % 13 == 0) ra = 8'd0;
            if (k % 10 == 0) rb = ra;
            if (k % 50 == 0) rb = 8'd0;
            run(ra, rb, 0, 1'b0);
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
